// File: rtl/mas_alu_sub_arbiter_if.sv
// Requester-side bundle of the shared-subtractor arbiter: operand requests in,
// difference/borrow responses out, one valid/ready pair per requester.
interface mas_alu_sub_arbiter_if #(
  parameter int BLEN = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BLEN-1:0] req_op1;
  logic [NREQ*BLEN-1:0] req_op2;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [BLEN-1:0]      rsp_res;
  logic                 rsp_borrow;

  modport master (
    output req_valid, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_borrow
  );

  modport slave (
    input  req_valid, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_borrow
  );
endinterface

// File: rtl/mas_alu_sub_arbiter.sv
// Round-robin sequencer sharing one registered subtractor among NREQ requesters;
// one operation in flight, response returned to the granted requester.
module mas_alu_sub_arbiter #(
  parameter int BLEN = 32,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mas_alu_sub_arbiter_if.slave   bus,
  output logic [BLEN-1:0]        sub_op1,
  output logic [BLEN-1:0]        sub_op2,
  input  logic                   sub_ready,
  input  logic [BLEN-1:0]        sub_res,
  output logic                   busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state;
  state_t          state_d;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            accept;
  logic            done;
  logic [BLEN-1:0] op1_sel;
  logic [BLEN-1:0] op2_sel;
  logic [BLEN-1:0] res_q;
  logic            borrow_q;

  function automatic logic borrow_of(input logic [BLEN-1:0] a, input logic [BLEN-1:0] b);
    return a < b;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  // Search from rr upward with wrap-around; first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign op1_sel = bus.req_op1[int'(grant)*BLEN +: BLEN];
  assign op2_sel = bus.req_op2[int'(grant)*BLEN +: BLEN];
  assign accept  = (state == IDLE) && found && !rst;
  assign done    = (state == RESP) && bus.rsp_ready[gid];

  always_comb begin
    state_d       = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          bus.req_ready = onehot(grant);
          state_d       = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      // The subtractor may still be in reset; hold operands until it answers.
      CAPTURE: if (sub_ready) state_d = RESP;
      RESP: begin
        bus.rsp_valid = onehot(gid);
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr    <= '0;
      gid   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        gid <= grant;
        rr  <= next_ptr(grant);
      end
    end
  end

  // Operands move only on accept; result only on CAPTURE->RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_op1  <= '0;
      sub_op2  <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      if (accept) begin
        sub_op1  <= op1_sel;
        sub_op2  <= op2_sel;
        borrow_q <= borrow_of(op1_sel, op2_sel);
      end
      if (state == CAPTURE && sub_ready) res_q <= sub_res;
    end
  end

  assign bus.rsp_res    = res_q;
  assign bus.rsp_borrow = borrow_q;

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rsp_valid));
endmodule

// File: tb/tb_mas_alu_sub_arbiter.sv
// Directed bench for mas_alu_sub_arbiter: a driver issues requests and queues the
// expected responses; a concurrent monitor pops and compares each response.
module tb_mas_alu_sub_arbiter;
  localparam int BLEN = 32;
  localparam int NREQ = 4;

  typedef struct {
    int              idx;
    logic [BLEN-1:0] res;
    logic            bor;
    int              t0;
    int              lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [BLEN-1:0] sub_op1;
  logic [BLEN-1:0] sub_op2;
  logic [BLEN-1:0] sub_res = '0;
  logic            sub_ready = 1'b0;
  logic            sub_en = 1'b0;
  logic            busy;
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  exp_t            exp_q[$];
  int              grant_log[$];
  int              grant_cyc[$];
  logic [BLEN-1:0] ex_r[NREQ];
  logic            ex_b[NREQ];
  logic            mon_prev = 1'b0;
  int              rr_order[5] = '{0, 1, 2, 3, 0};

  mas_alu_sub_arbiter_if #(.BLEN(BLEN), .NREQ(NREQ)) bus();

  mas_alu_sub_arbiter #(.BLEN(BLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sub_op1   (sub_op1),
    .sub_op2   (sub_op2),
    .sub_ready (sub_ready),
    .sub_res   (sub_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared subtractor stand-in: one-cycle registered difference, ready tracks sub_en.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    sub_ready <= sub_en;
    sub_res   <= sub_en ? sub_op1 - sub_op2 : '0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", nm, cyc);
  endtask

  task automatic set_req(input int i, input logic [BLEN-1:0] a, input logic [BLEN-1:0] b,
                         input logic [BLEN-1:0] r, input logic bo);
    bus.req_op1[i*BLEN +: BLEN] = a;
    bus.req_op2[i*BLEN +: BLEN] = b;
    ex_r[i] = r;
    ex_b[i] = bo;
  endtask

  // Observe n grants; returns at the negedge following the last accept edge.
  task automatic run_grants(input int n, input bit one_shot, input int lat);
    int cnt;
    int guard;
    exp_t e;
    cnt = 0;
    guard = 0;
    grant_log.delete();
    grant_cyc.delete();
    while (cnt < n) begin
      #1;
      if (bus.req_ready != '0) begin
        int k;
        k = 0;
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) k = j;
        chk("req_ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
        e.idx = k; e.res = ex_r[k]; e.bor = ex_b[k]; e.t0 = cyc; e.lat = lat;
        exp_q.push_back(e);
        grant_log.push_back(k);
        grant_cyc.push_back(cyc);
        cnt++;
        @(negedge clk);
        if (one_shot) bus.req_valid[k] = 1'b0;
        if (cnt == n) bus.req_valid = '0;
      end else begin
        guard++;
        if (guard > 100) begin
          fail("grant_timeout");
          bus.req_valid = '0;
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) return;
    end
    fail("idle_timeout");
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        mon_prev = 1'b0;
      end else begin
        if (busy) chk("req_ready_while_busy", 64'(bus.req_ready), 64'd0);
        if (bus.rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
          end else begin
            if (!mon_prev)
              chk("rsp_latency", 64'(cyc), 64'(exp_q[0].t0 + 3 + exp_q[0].lat));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'd1 << exp_q[0].idx);
            chk("rsp_res", 64'(bus.rsp_res), 64'(exp_q[0].res));
            chk("rsp_borrow", 64'(bus.rsp_borrow), 64'(exp_q[0].bor));
            if ((bus.rsp_valid & bus.rsp_ready) != '0) void'(exp_q.pop_front());
          end
        end
        mon_prev = |bus.rsp_valid;
      end
    end
  endtask

  task automatic main_seq();
    // Reset with requests pending: nothing may be granted.
    rst = 1'b1;
    sub_en = 1'b0;
    bus.req_valid = 4'b0101;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    bus.rsp_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sub_op1", 64'(sub_op1), 64'd0);
    chk("rst_sub_op2", 64'(sub_op2), 64'd0);
    chk("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
    chk("rst_rsp_borrow", 64'(bus.rsp_borrow), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    sub_en = 1'b1;
    @(negedge clk);

    // Single op from requester 2: 10 - 3 = 7.
    set_req(2, 32'd10, 32'd3, 32'd7, 1'b0);
    bus.req_valid = 4'b0100;
    run_grants(1, 1'b1, 0);
    if (grant_log.size() == 1) chk("single_grant", 64'(grant_log[0]), 64'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_at_t0p4", 64'(busy), 64'd0);

    // Wrap-around with borrow: 0 - 1.
    set_req(3, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    bus.req_valid = 4'b1000;
    run_grants(1, 1'b1, 0);
    if (grant_log.size() == 1) chk("wrap_grant", 64'(grant_log[0]), 64'd3);
    wait_idle();

    // All four requesters continuously valid.
    set_req(0, 32'd100, 32'd40, 32'd60, 1'b0);
    set_req(1, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1);
    set_req(2, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    bus.req_valid = 4'b1111;
    run_grants(5, 1'b0, 0);
    if (grant_log.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(rr_order[i]));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd4);
    end
    wait_idle();

    // Backpressure on requester 1; other rsp_ready bits high and requester 0 waiting.
    set_req(1, 32'd1000, 32'd1, 32'd999, 1'b0);
    set_req(0, 32'd50, 32'd8, 32'd42, 1'b0);
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0011;
    run_grants(1, 1'b1, 0);
    if (grant_log.size() == 1) chk("bp_grant", 64'(grant_log[0]), 64'd1);
    bus.req_valid = 4'b0001;
    begin
      bit seen;
      seen = 1'b0;
      for (int g = 0; g < 20 && !seen; g++) begin
        @(negedge clk);
        #1;
        seen = |bus.rsp_valid;
      end
      if (!seen) fail("bp_rsp_timeout");
    end
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", 64'(bus.rsp_valid), 64'b0010);
      chk("bp_hold_res", 64'(bus.rsp_res), 64'd999);
    end
    bus.rsp_ready = '1;

    // Requester 0 granted next; subtractor not ready for 3 CAPTURE cycles.
    run_grants(1, 1'b1, 3);
    sub_en = 1'b0;
    if (grant_log.size() == 1) chk("slow_grant", 64'(grant_log[0]), 64'd0);
    repeat (3) @(negedge clk);
    sub_en = 1'b1;
    wait_idle();

    // Reset while in CAPTURE: response discarded, pointer back to 0.
    set_req(2, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);
    bus.req_valid = 4'b0100;
    run_grants(1, 1'b1, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sub_op1", 64'(sub_op1), 64'd0);
    chk("midrst_rsp_res", 64'(bus.rsp_res), 64'd0);
    chk("midrst_rsp_borrow", 64'(bus.rsp_borrow), 64'd0);
    set_req(1, 32'd20, 32'd30, 32'hFFFF_FFF6, 1'b1);
    set_req(3, 32'd9, 32'd4, 32'd5, 1'b0);
    bus.req_valid = 4'b1010;
    run_grants(2, 1'b1, 0);
    if (grant_log.size() == 2) begin
      chk("post_rst_grant0", 64'(grant_log[0]), 64'd1);
      chk("post_rst_grant1", 64'(grant_log[1]), 64'd3);
    end
    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
